// File: rtl/branch_resolver.sv
// In-flight conditional branch queue: resolves the oldest branch in EX, registered result (1 cycle), flushes on mispredict.
// predReady drops when the queue is full or during the flush cycle; optional counters under BR_STATS_EN.
module branch_resolver #(
   parameter int DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        predValid,
   input  logic        predTaken,
   input  logic [63:0] predPc,
   input  logic [63:0] predImm,
   output logic        predReady,
   input  logic        exValid,
   input  logic        exTaken,
   output logic        isBranch,
   output logic        lastBranchTaken,
   output logic        lastBranchPrediction,
   output logic [63:0] lastPcValue,
   output logic [63:0] lastPcPlusImmediate,
   output logic        flush,
   output logic        protoErr
`ifdef BR_STATS_EN
   ,
   output logic [31:0] branchCount,
   output logic [31:0] mispredictCount
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   localparam logic [0:0] RUN   = 1'b0;
   localparam logic [0:0] FLUSH = 1'b1;

   logic [0:0]    state;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic          ready_en;

   logic          mem_taken [DEPTH];
   logic [63:0]   mem_pc    [DEPTH];
   logic [63:0]   mem_tgt   [DEPTH];

   logic          in_run;
   logic          push;
   logic          pop;
   logic          mispredict;
   logic          proto_hit;

   // ready_en keeps predReady low through reset and until the first edge after release
   always_comb begin
      in_run     = (state == RUN);
      predReady  = ready_en && in_run && (count < CW'(DEPTH));
      push       = predValid && predReady;
      pop        = in_run && exValid && (count != '0);
      mispredict = pop && (exTaken != mem_taken[head]);
      proto_hit  = in_run && exValid && (count == '0);
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_taken[tail] <= predTaken;
         mem_pc[tail]    <= predPc;
         mem_tgt[tail]   <= predPc + predImm;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state                <= RUN;
         head                 <= '0;
         tail                 <= '0;
         count                <= '0;
         ready_en             <= 1'b0;
         isBranch             <= 1'b0;
         flush                <= 1'b0;
         protoErr             <= 1'b0;
         lastBranchTaken      <= 1'b0;
         lastBranchPrediction <= 1'b0;
         lastPcValue          <= '0;
         lastPcPlusImmediate  <= '0;
      end else begin
         ready_en <= 1'b1;
         isBranch <= pop;
         flush    <= mispredict;
         if (proto_hit)
            protoErr <= 1'b1;
         if (pop) begin
            lastBranchTaken      <= exTaken;
            lastBranchPrediction <= mem_taken[head];
            lastPcValue          <= mem_pc[head];
            lastPcPlusImmediate  <= mem_tgt[head];
         end
         if (state == FLUSH) begin
            state <= RUN;
         end else if (mispredict) begin
            // a push in the same cycle is discarded along with the rest of the queue
            state <= FLUSH;
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push)
               tail <= tail + 1'b1;
            if (pop)
               head <= head + 1'b1;
            if (push && !pop)
               count <= count + 1'b1;
            else if (!push && pop)
               count <= count - 1'b1;
         end
      end
   end

`ifdef BR_STATS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         branchCount     <= '0;
         mispredictCount <= '0;
      end else begin
         if (pop && (branchCount != '1))
            branchCount <= branchCount + 1'b1;
         if (mispredict && (mispredictCount != '1))
            mispredictCount <= mispredictCount + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver (DEPTH=4), expected values worked out by hand.
module tb_branch_resolver;

   logic        clock;
   logic        reset_n;
   logic        predValid;
   logic        predTaken;
   logic [63:0] predPc;
   logic [63:0] predImm;
   logic        predReady;
   logic        exValid;
   logic        exTaken;
   logic        isBranch;
   logic        lastBranchTaken;
   logic        lastBranchPrediction;
   logic [63:0] lastPcValue;
   logic [63:0] lastPcPlusImmediate;
   logic        flush;
   logic        protoErr;
`ifdef BR_STATS_EN
   logic [31:0] branchCount;
   logic [31:0] mispredictCount;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   branch_resolver #(.DEPTH(4)) dut (
      .clock                (clock),
      .reset_n              (reset_n),
      .predValid            (predValid),
      .predTaken            (predTaken),
      .predPc               (predPc),
      .predImm              (predImm),
      .predReady            (predReady),
      .exValid              (exValid),
      .exTaken              (exTaken),
      .isBranch             (isBranch),
      .lastBranchTaken      (lastBranchTaken),
      .lastBranchPrediction (lastBranchPrediction),
      .lastPcValue          (lastPcValue),
      .lastPcPlusImmediate  (lastPcPlusImmediate),
      .flush                (flush),
      .protoErr             (protoErr)
`ifdef BR_STATS_EN
      ,
      .branchCount          (branchCount),
      .mispredictCount      (mispredictCount)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_pred(input logic v, input logic t, input logic [63:0] pc, input logic [63:0] imm);
      predValid = v;
      predTaken = t;
      predPc    = pc;
      predImm   = imm;
   endtask

   initial begin
      reset_n   = 1'b0;
      set_pred(1'b0, 1'b0, 64'h0, 64'h0);
      exValid   = 1'b0;
      exTaken   = 1'b0;

      // reset state
      step();
      step();
      check("rst_predReady", predReady, 0);
      check("rst_isBranch", isBranch, 0);
      check("rst_flush", flush, 0);
      check("rst_protoErr", protoErr, 0);
      check("rst_target", lastPcPlusImmediate, 0);
      reset_n = 1'b1;
      step();
      check("rel_predReady", predReady, 1);
      check("rel_isBranch", isBranch, 0);

      // correctly predicted taken branch
      set_pred(1'b1, 1'b1, 64'h100, 64'h20);
      step();
      set_pred(1'b0, 1'b0, 64'h0, 64'h0);
      exValid = 1'b1; exTaken = 1'b1;
      step();
      exValid = 1'b0;
      check("t1_isBranch", isBranch, 1);
      check("t1_target", lastPcPlusImmediate, 64'h120);
      check("t1_pc", lastPcValue, 64'h100);
      check("t1_pred", lastBranchPrediction, 1);
      check("t1_taken", lastBranchTaken, 1);
      check("t1_flush", flush, 0);
      step();
      check("t1_pulse_end", isBranch, 0);
      check("t1_hold", lastPcPlusImmediate, 64'h120);

      // mispredict flushes queue, flush-cycle inputs ignored
      set_pred(1'b1, 1'b0, 64'h200, 64'h8);
      step();
      set_pred(1'b1, 1'b1, 64'h300, 64'h8);
      step();
      set_pred(1'b0, 1'b0, 64'h0, 64'h0);
      exValid = 1'b1; exTaken = 1'b1;
      step();
      check("t2_flush", flush, 1);
      check("t2_isBranch", isBranch, 1);
      check("t2_predReady", predReady, 0);
      check("t2_pc", lastPcValue, 64'h200);
      check("t2_pred", lastBranchPrediction, 0);
      set_pred(1'b1, 1'b1, 64'h999, 64'h0);
      exValid = 1'b1; exTaken = 1'b0;
      step();
      set_pred(1'b0, 1'b0, 64'h0, 64'h0);
      exValid = 1'b0;
      check("t2_flush_end", flush, 0);
      check("t2_isBranch_end", isBranch, 0);
      check("t2_ready_back", predReady, 1);
      check("t2_no_proto", protoErr, 0);

      // fill to DEPTH; queue must be empty after flush
      for (int i = 0; i < 4; i++) begin
         set_pred(1'b1, 1'b0, 64'h1000 + 64'(i * 16), 64'h4);
         step();
         check($sformatf("t3_ready_%0d", i), predReady, (i < 3) ? 1 : 0);
      end
      set_pred(1'b1, 1'b0, 64'hBAD, 64'h4);
      exValid = 1'b1; exTaken = 1'b0;
      step();
      set_pred(1'b0, 1'b0, 64'h0, 64'h0);
      check("t3_isBranch", isBranch, 1);
      check("t3_pc0", lastPcValue, 64'h1000);
      check("t3_tgt0", lastPcPlusImmediate, 64'h1004);
      check("t3_flush", flush, 0);
      check("t3_ready_after", predReady, 1);
      for (int j = 1; j < 4; j++) begin
         step();
         check($sformatf("t3_pc%0d", j), lastPcValue, 64'h1000 + 64'(j * 16));
         check($sformatf("t3_isBranch%0d", j), isBranch, 1);
      end

      // exValid on empty queue: sticky protoErr, no resolution
      step();
      exValid = 1'b0;
      check("t4_isBranch", isBranch, 0);
      check("t4_protoErr", protoErr, 1);
      step();
      step();
      check("t4_sticky", protoErr, 1);
      check("t4_isBranch_idle", isBranch, 0);

      // target wrap, plus push and pop in the same cycle
      set_pred(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20);
      step();
      set_pred(1'b1, 1'b0, 64'h4000, 64'h100);
      exValid = 1'b1; exTaken = 1'b1;
      step();
      set_pred(1'b0, 1'b0, 64'h0, 64'h0);
      exTaken = 1'b0;
      check("t5_wrap_tgt", lastPcPlusImmediate, 64'h10);
      check("t5_wrap_pc", lastPcValue, 64'hFFFF_FFFF_FFFF_FFF0);
      check("t5_flush", flush, 0);
      step();
      exValid = 1'b0;
      check("t5_second_tgt", lastPcPlusImmediate, 64'h4100);
      check("t5_second_isBranch", isBranch, 1);
      step();
      check("t5_idle", isBranch, 0);

      // asynchronous reset with 3 queued entries
      for (int i = 0; i < 4; i++) begin
         set_pred(1'b1, 1'b0, 64'h5000 + 64'(i * 16), 64'h8);
         step();
      end
      set_pred(1'b0, 1'b0, 64'h0, 64'h0);
      exValid = 1'b1; exTaken = 1'b0;
      step();
      exValid = 1'b0;
      check("t6_pre_isBranch", isBranch, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_async_isBranch", isBranch, 0);
      check("t6_async_pc", lastPcValue, 0);
      check("t6_async_protoErr", protoErr, 0);
      check("t6_async_predReady", predReady, 0);
      step();
      reset_n = 1'b1;
      step();
      check("t6_rel_predReady", predReady, 1);
      check("t6_rel_isBranch", isBranch, 0);
      exValid = 1'b1; exTaken = 1'b0;
      step();
      exValid = 1'b0;
      check("t6_empty_isBranch", isBranch, 0);
      check("t6_empty_protoErr", protoErr, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
